heaa_arbiter: RTL and testbench

HEAA_ARBITER -- requirements
Module: heaa_arbiter

---
 rtl/heaa_arbiter.sv | 165 ++++++++++++++++
 tb/tb_heaa_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/heaa_arbiter.sv
// Round-robin arbiter that time-shares one HEAA approximate adder among four
// requesters, with a registered result and a valid/ready handshake on the output.

module heaa_adder #(
    parameter int unsigned ADDER_LENGTH   = 32,
    parameter int unsigned IMPRECISE_PART = 16
) (
    input  logic [ADDER_LENGTH-1:0] a,
    input  logic [ADDER_LENGTH-1:0] b,
    output logic [ADDER_LENGTH:0]   sum
);

    localparam int unsigned HI_W = ADDER_LENGTH - IMPRECISE_PART;

    logic [IMPRECISE_PART-2:0] lo;
    logic                      mid;
    logic                      mid_c;
    logic [HI_W:0]             hi;

    // Low part is OR-approximated; the top imprecise bit alone generates the carry.
    always_comb begin
        lo    = a[IMPRECISE_PART-2:0] | b[IMPRECISE_PART-2:0];
        mid_c = a[IMPRECISE_PART-1] & b[IMPRECISE_PART-1];
        mid   = (a[IMPRECISE_PART-1] | b[IMPRECISE_PART-1]) & ~mid_c;
        hi    = {1'b0, a[ADDER_LENGTH-1:IMPRECISE_PART]}
              + {1'b0, b[ADDER_LENGTH-1:IMPRECISE_PART]}
              + (HI_W+1)'(mid_c);
        sum   = {hi, mid, lo};
    end

endmodule

module heaa_arbiter #(
    parameter int unsigned ADDER_LENGTH   = 32,
    parameter int unsigned IMPRECISE_PART = 16,
    parameter int unsigned NUM_REQ        = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDER_LENGTH-1:0] req_a,
    input  logic [NUM_REQ*ADDER_LENGTH-1:0] req_b,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [ADDER_LENGTH:0]           res_sum,
    output logic [1:0]                      res_id,
    output logic [15:0]                     op_count,
    output logic                            busy
);

    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ID_W-1:0]         last_grant;
    logic [ID_W-1:0]         grant;
    logic [ID_W-1:0]         grant_idx;
    logic [ID_W-1:0]         cand;
    logic                    grant_found;
    logic [ADDER_LENGTH-1:0] op_a;
    logic [ADDER_LENGTH-1:0] op_b;
    logic [ADDER_LENGTH:0]   adder_sum;

    heaa_adder #(
        .ADDER_LENGTH  (ADDER_LENGTH),
        .IMPRECISE_PART(IMPRECISE_PART)
    ) u_adder (
        .a  (op_a),
        .b  (op_b),
        .sum(adder_sum)
    );

    // Round-robin search beginning just after the previous winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = last_grant + ID_W'(k + 1);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = COMPUTE;
                end
            end
            COMPUTE: state_nxt = HOLD;
            HOLD: begin
                if (res_valid && res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            req_ready = '0;
        end
    end

    // Operand capture, result register and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            grant      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_id     <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a       <= req_a[grant_idx*ADDER_LENGTH +: ADDER_LENGTH];
                        op_b       <= req_b[grant_idx*ADDER_LENGTH +: ADDER_LENGTH];
                        grant      <= grant_idx;
                        last_grant <= grant_idx;
                    end
                end
                COMPUTE: begin
                    res_sum   <= adder_sum;
                    res_id    <= grant;
                    res_valid <= 1'b1;
                end
                HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_heaa_arbiter.sv
// Scoreboard bench for heaa_arbiter: directed operand vectors per requester,
// expected results queued at issue time and popped on every result handshake.

module tb_heaa_arbiter;

    localparam int unsigned AL = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [1:0]  id;
        logic [AL:0] sum;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*AL-1:0]   req_a;
    logic [NR*AL-1:0]   req_b;
    logic               res_valid;
    logic               res_ready;
    logic [AL:0]        res_sum;
    logic [1:0]         res_id;
    logic [15:0]        op_count;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    exp_t        sb_q[$];
    logic [31:0] pa [NR][DEPTH];
    logic [31:0] pb [NR][DEPTH];
    int          head [NR] = '{0, 0, 0, 0};
    int          tail [NR] = '{0, 0, 0, 0};
    logic [3:0]  drv_hs;
    logic [15:0] exp_count;

    always #5 clk = ~clk;

    heaa_arbiter #(
        .ADDER_LENGTH  (32),
        .IMPRECISE_PART(16),
        .NUM_REQ       (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum  (res_sum),
        .res_id   (res_id),
        .op_count (op_count),
        .busy     (busy)
    );

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic pend(input int i, input logic [31:0] a, input logic [31:0] b);
        pa[i][tail[i]] = a;
        pb[i][tail[i]] = b;
        tail[i]++;
    endtask

    task automatic expect_res(input logic [1:0] id, input logic [AL:0] sum);
        exp_t e;
        e.id  = id;
        e.sum = sum;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy && req_valid == '0) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'd0, 64'd1);
    endtask

    // Requester model: holds valid and operands until its req_ready is seen.
    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(negedge clk);
            drv_hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (drv_hs[i]) begin
                    head[i]++;
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && head[i] != tail[i]) begin
                    req_a[i*AL +: AL] = pa[i][head[i]];
                    req_b[i*AL +: AL] = pb[i][head[i]];
                    req_valid[i]      = 1'b1;
                end
            end
        end
    end

    // Monitor: result scoreboard plus per-cycle invariants.
    initial begin
        exp_t e;
        exp_count = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_count = '0;
            end else begin
                check("op_count", 64'(op_count), 64'(exp_count));
                check("req_ready_onehot", 64'($onehot0(req_ready)), 64'd1);
                if (busy) check("req_ready_busy", 64'(req_ready), 64'd0);
                if (res_valid && res_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_result", 64'(res_id), 64'hdead);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_res_id", 64'(res_id), 64'(e.id));
                        check("sb_res_sum", 64'(res_sum), 64'(e.sum));
                    end
                    exp_count = exp_count + 16'd1;
                end
            end
        end
    end

    initial begin
        bit seen;
        rst       = 1'b1;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_sum", 64'(res_sum), 64'd0);
        check("rst_res_id", 64'(res_id), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fairness: all four held valid, requester 0 reloads a second operation.
        pend(0, 32'h0000_0001, 32'h0000_0002);
        pend(0, 32'h0000_7FFF, 32'h0000_0001);
        pend(1, 32'h1234_0000, 32'h0001_0000);
        pend(2, 32'h0000_8000, 32'h0000_8000);
        pend(3, 32'h8000_0000, 32'h8000_0000);
        expect_res(2'd0, 33'h0_0000_0003);
        expect_res(2'd1, 33'h0_1235_0000);
        expect_res(2'd2, 33'h0_0001_0000);
        expect_res(2'd3, 33'h1_0000_0000);
        expect_res(2'd0, 33'h0_0000_7FFF);
        wait_drain();

        // Single request with cycle-level timing.
        pend(0, 32'h0001_8001, 32'h0001_8002);
        expect_res(2'd0, 33'h0_0003_0003);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1'b1;
        end
        check("single_req_ready", 64'(req_ready), 64'h1);
        @(negedge clk);
        check("single_compute_ready", 64'(req_ready), 64'd0);
        check("single_compute_busy", 64'(busy), 64'd1);
        check("single_compute_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        check("single_res_valid", 64'(res_valid), 64'd1);
        check("single_res_sum", 64'(res_sum), 64'h0_0003_0003);
        check("single_res_id", 64'(res_id), 64'd0);
        @(negedge clk);
        check("single_after_valid", 64'(res_valid), 64'd0);
        check("single_after_count", 64'(op_count), 64'd6);
        wait_drain();

        // Carry-out and low-part approximation.
        pend(0, 32'hFFFF_0000, 32'h0001_0000);
        expect_res(2'd0, 33'h1_0000_0000);
        pend(0, 32'h0000_00FF, 32'h0000_0001);
        expect_res(2'd0, 33'h0_0000_00FF);
        wait_drain();

        // Backpressure: result held for five cycles while requester 1 waits.
        @(posedge clk);
        #1 res_ready = 1'b0;
        pend(0, 32'h0005_4000, 32'h0003_C000);
        expect_res(2'd0, 33'h0_0008_C000);
        expect_res(2'd1, 33'h0_0000_0011);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("bp_res_valid_seen", 64'(seen), 64'd1);
        pend(1, 32'h0000_0010, 32'h0000_0001);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_res_valid", 64'(res_valid), 64'd1);
            check("bp_res_sum", 64'(res_sum), 64'h0_0008_C000);
            check("bp_res_id", 64'(res_id), 64'd0);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_drain();

        // Reset while requester 1's operation is in COMPUTE.
        pend(1, 32'h0000_0001, 32'h0000_0001);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (busy && !res_valid) seen = 1'b1;
        end
        check("rm_compute_seen", 64'(seen), 64'd1);
        #1 rst = 1'b1;
        pend(0, 32'h0002_0000, 32'h0003_0000);
        pend(2, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_res(2'd0, 33'h0_0005_0000);
        expect_res(2'd2, 33'h0_FFFF_FFFF);
        @(negedge clk);
        check("rm_rst_req_ready", 64'(req_ready), 64'd0);
        check("rm_rst_res_valid", 64'(res_valid), 64'd0);
        check("rm_rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rm_req_ready", 64'(req_ready), 64'h1);
        check("rm_res_valid", 64'(res_valid), 64'd0);
        check("rm_op_count", 64'(op_count), 64'd0);
        wait_drain();
        @(negedge clk);
        check("final_op_count", 64'(op_count), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
